// File: rtl/im_window_gen.sv
// -----------------------------------------------------------------------------
// im_window_gen
// Sliding-window generator for a raster-order pixel stream. Produces one
// MASK_WIDTH x MASK_WIDTH window per output position, either interior-only
// (border_mode=0) or one window per image pixel with zero padding inserted
// internally (border_mode=1). Mode is latched when a frame starts.
//
// Ports:
//   clk          system clock
//   reset_in     asynchronous active-high reset
//   pix_in_valid source has a pixel on pix_in (held until accepted)
//   pix_in       unsigned pixel
//   in_ready     pixel on pix_in is consumed this cycle when pix_in_valid
//   border_mode  0 = no-border, 1 = zero-pad (sampled at frame start)
//   win_valid    win_out / win_row / win_col valid this cycle
//   win_out      window, element (i,j) at [(i*K+j+1)*PIX_BIT-1 -: PIX_BIT]
//   win_row      image row of the window centre
//   win_col      image column of the window centre
//   busy         frame in progress
//   frame_done   pulse with the last window of a frame
// -----------------------------------------------------------------------------
module im_window_gen #(
   parameter int PIX_BIT    = 8,
   parameter int MASK_WIDTH = 7,
   parameter int ROW_WIDTH  = 100,
   parameter int COL_WIDTH  = 100,
   parameter int CNT_BIT    = 8
) (
   input  logic                                    clk,
   input  logic                                    reset_in,
   input  logic                                    pix_in_valid,
   input  logic [PIX_BIT-1:0]                      pix_in,
   output logic                                    in_ready,
   input  logic                                    border_mode,
   output logic                                    win_valid,
   output logic [MASK_WIDTH*MASK_WIDTH*PIX_BIT-1:0] win_out,
   output logic [CNT_BIT-1:0]                      win_row,
   output logic [CNT_BIT-1:0]                      win_col,
   output logic                                    busy,
   output logic                                    frame_done
);

   localparam int K        = MASK_WIDTH;
   localparam int H        = (K - 1) / 2;
   localparam int LB_DEPTH = COL_WIDTH + 2 * H;
   localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int WW       = K * K * PIX_BIT;

   localparam logic [CNT_BIT-1:0] H_C       = CNT_BIT'(H);
   localparam logic [CNT_BIT-1:0] H2_C      = CNT_BIT'(2 * H);
   localparam logic [CNT_BIT-1:0] KM1_C     = CNT_BIT'(K - 1);
   localparam logic [CNT_BIT-1:0] RH_C      = CNT_BIT'(ROW_WIDTH + H);
   localparam logic [CNT_BIT-1:0] CH_C      = CNT_BIT'(COL_WIDTH + H);
   localparam logic [CNT_BIT-1:0] PR_LAST_1 = CNT_BIT'(ROW_WIDTH + 2 * H - 1);
   localparam logic [CNT_BIT-1:0] PR_LAST_0 = CNT_BIT'(ROW_WIDTH - 1);
   localparam logic [CNT_BIT-1:0] PC_LAST_1 = CNT_BIT'(COL_WIDTH + 2 * H - 1);
   localparam logic [CNT_BIT-1:0] PC_LAST_0 = CNT_BIT'(COL_WIDTH - 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [CNT_BIT-1:0]   pr_q, pr_d;
   logic [CNT_BIT-1:0]   pc_q, pc_d;

   logic                 active;
   logic                 is_pad;
   logic                 advance;
   logic                 emit;
   logic                 at_last;
   logic [CNT_BIT-1:0]   last_r;
   logic [CNT_BIT-1:0]   last_c;
   logic [PIX_BIT-1:0]   new_pix;
   logic [AW-1:0]        lb_addr;

   // Position bookkeeping in the (possibly padded) virtual frame
   assign active   = (state_q == S_ACTIVE);
   assign is_pad   = mode_q && ((pr_q < H_C) || (pr_q >= RH_C) ||
                                (pc_q < H_C) || (pc_q >= CH_C));
   // Pad positions advance on their own; pixel positions wait for the source
   assign advance  = active && (is_pad || pix_in_valid);
   assign in_ready = active && !is_pad;
   assign busy     = active;
   assign last_r   = mode_q ? PR_LAST_1 : PR_LAST_0;
   assign last_c   = mode_q ? PC_LAST_1 : PC_LAST_0;
   assign at_last  = (pr_q == last_r) && (pc_q == last_c);
   assign emit     = advance && (pr_q >= KM1_C) && (pc_q >= KM1_C);
   assign new_pix  = is_pad ? '0 : pix_in;
   assign lb_addr  = pc_q[AW-1:0];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         pr_q    <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pr_q    <= pr_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pr_d    = pr_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            // Start cycle only: the pixel is consumed once ACTIVE
            if (pix_in_valid) begin
               mode_d  = border_mode;
               pr_d    = '0;
               pc_d    = '0;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (advance) begin
               if (pc_q == last_c) begin
                  pc_d = '0;
                  if (pr_q == last_r) begin
                     state_d = S_IDLE;
                  end else begin
                     pr_d = pr_q + 1'b1;
                  end
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------- line buffers
   // lb_rd[0] holds the row above the current one at this column,
   // lb_rd[K-2] the row K-1 above; each advance pushes the column down one.
   logic [PIX_BIT-1:0] lb_rd [K-1];
   logic [PIX_BIT-1:0] lb_wr [K-1];

   genvar gi, gj;
   generate
      for (gi = 0; gi < K - 1; gi++) begin : g_lb
         logic [PIX_BIT-1:0] mem [LB_DEPTH];

         if (gi == 0) begin : g_first
            assign lb_wr[gi] = new_pix;
         end else begin : g_chain
            assign lb_wr[gi] = lb_rd[gi-1];
         end

         assign lb_rd[gi] = mem[lb_addr];

         always_ff @(posedge clk) begin
            if (advance) begin
               mem[lb_addr] <= lb_wr[gi];
            end
         end
      end
   endgenerate

   // ---------------------------------------------------- window register
   logic [PIX_BIT-1:0] win_q [K][K];
   logic [PIX_BIT-1:0] win_d [K][K];
   logic [WW-1:0]      win_flat_d;

   // Shift left by one column; the new right column is the line-buffer
   // taps (oldest row on top) plus the current pixel at the bottom.
   generate
      for (gi = 0; gi < K; gi++) begin : g_row
         for (gj = 0; gj < K; gj++) begin : g_col
            if (gj < K - 1) begin : g_shift
               assign win_d[gi][gj] = win_q[gi][gj+1];
            end else if (gi == K - 1) begin : g_new
               assign win_d[gi][gj] = new_pix;
            end else begin : g_tap
               assign win_d[gi][gj] = lb_rd[K-2-gi];
            end
            assign win_flat_d[(gi*K+gj)*PIX_BIT +: PIX_BIT] = win_d[gi][gj];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         win_q <= '{default: '0};
      end else if (advance) begin
         win_q <= win_d;
      end
   end

   // -------------------------------------------------------- output stage
   // Separate output registers so win_out holds between valid windows even
   // though the window array keeps shifting through border columns.
   logic               win_valid_q;
   logic               frame_done_q;
   logic [WW-1:0]      win_out_q;
   logic [CNT_BIT-1:0] win_row_q;
   logic [CNT_BIT-1:0] win_col_q;

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_out_q    <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
      end else begin
         win_valid_q  <= emit;
         frame_done_q <= emit && at_last;
         if (emit) begin
            win_out_q <= win_flat_d;
            // Centre lies H behind the bottom-right in image coordinates,
            // plus the H pad offset in zero-pad mode.
            win_row_q <= pr_q - (mode_q ? H2_C : H_C);
            win_col_q <= pc_q - (mode_q ? H2_C : H_C);
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign win_out    = win_out_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;

endmodule

// File: tb/tb_im_window_gen.sv
module tb_im_window_gen;

   localparam int PIX_BIT = 8;
   localparam int K       = 3;
   localparam int R       = 5;
   localparam int C       = 5;
   localparam int CNT_BIT = 4;
   localparam int WW      = K * K * PIX_BIT;

   logic               clk = 1'b0;
   logic               reset_in;
   logic               pix_in_valid;
   logic [PIX_BIT-1:0] pix_in;
   logic               in_ready;
   logic               border_mode;
   logic               win_valid;
   logic [WW-1:0]      win_out;
   logic [CNT_BIT-1:0] win_row;
   logic [CNT_BIT-1:0] win_col;
   logic               busy;
   logic               frame_done;

   im_window_gen #(
      .PIX_BIT(PIX_BIT), .MASK_WIDTH(K), .ROW_WIDTH(R),
      .COL_WIDTH(C), .CNT_BIT(CNT_BIT)
   ) dut (
      .clk(clk), .reset_in(reset_in), .pix_in_valid(pix_in_valid),
      .pix_in(pix_in), .in_ready(in_ready), .border_mode(border_mode),
      .win_valid(win_valid), .win_out(win_out), .win_row(win_row),
      .win_col(win_col), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] win;
      int            row;
      int            col;
      bit            last;
   } exp_t;

   typedef struct {
      bit            mode;
      bit            bubble;
      bit            flip;
      int            exp_win;
      int            exp_active;   // -1 = not checked
      int            exp_ready;    // -1 = not checked
      logic [WW-1:0] first;
      logic [WW-1:0] last;
   } vec_t;

   exp_t          sb_q[$];
   exp_t          mon_e;
   vec_t          vecs[5];
   int            total = 0;
   int            bad = 0;
   int            n_win;
   bit            got_first;
   bit            sb_en;
   logic [WW-1:0] first_w;
   logic [WW-1:0] last_w;

   function automatic int pix(input int r, input int c);
      return 5 * r + c + 1;
   endfunction

   function automatic logic [WW-1:0] mk9(input int e [9]);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < 9; k++) w[k*8 +: 8] = e[k][7:0];
      return w;
   endfunction

   // Reference model: window centred on image (r,c), zero outside the image
   task automatic push_frame(input bit mode);
      int   lo, hi;
      exp_t e;
      lo = mode ? 0 : 1;
      hi = mode ? 4 : 3;
      for (int r = lo; r <= hi; r++) begin
         for (int c = lo; c <= hi; c++) begin
            e.win = '0;
            for (int i = 0; i < K; i++) begin
               for (int j = 0; j < K; j++) begin
                  int rr, cc, v;
                  rr = r - 1 + i;
                  cc = c - 1 + j;
                  v = (rr >= 0 && rr < R && cc >= 0 && cc < C) ? pix(rr, cc) : 0;
                  e.win[(i*K+j)*8 +: 8] = v[7:0];
               end
            end
            e.row  = r;
            e.col  = c;
            e.last = (r == hi) && (c == hi);
            sb_q.push_back(e);
         end
      end
   endtask

   // Output monitor / scoreboard
   always @(negedge clk) begin
      if (!reset_in && sb_en) begin
         if (win_valid) begin
            n_win++;
            if (!got_first) begin
               first_w   = win_out;
               got_first = 1'b1;
            end
            if (frame_done) last_w = win_out;
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL window: unexpected window row=%0d col=%0d win=%h, none required",
                        win_row, win_col, win_out);
            end else begin
               mon_e = sb_q.pop_front();
               if (win_out !== mon_e.win || win_row !== mon_e.row[3:0] ||
                   win_col !== mon_e.col[3:0] || frame_done !== mon_e.last) begin
                  bad++;
                  $display("FAIL window: got row=%0d col=%0d done=%0b win=%h, required row=%0d col=%0d done=%0b win=%h",
                           win_row, win_col, frame_done, win_out,
                           mon_e.row, mon_e.col, mon_e.last, mon_e.win);
               end else begin
                  $display("window row=%0d col=%0d done=%0b win=%h", win_row, win_col,
                           frame_done, win_out);
               end
            end
         end else if (frame_done) begin
            total++;
            bad++;
            $display("FAIL frame_done: got 1 without win_valid, required 0");
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      total++;
      if ({in_ready, busy, win_valid, frame_done, win_out, win_row, win_col} !== '0) begin
         bad++;
         $display("FAIL %s: got ready=%b busy=%b valid=%b done=%b row=%0d col=%0d win=%h, required all 0",
                  name, in_ready, busy, win_valid, frame_done, win_row, win_col, win_out);
      end else begin
         $display("%s: all outputs 0", name);
      end
   endtask

   // Drives one frame; abort_at>0 asserts reset after that many accepted pixels
   task automatic run_frame(input bit mode, input bit bubble, input bit flip,
                            input int abort_at, output int n_act, output int n_rdy);
      int idx;
      bit acc, seen, done;
      idx = 0; n_act = 0; n_rdy = 0; seen = 0; done = 0;
      if (abort_at == 0) push_frame(mode);
      got_first = 1'b0;
      n_win = 0;
      @(negedge clk);
      border_mode  = mode;
      pix_in       = 8'd1;
      pix_in_valid = 1'b1;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         if (busy) begin
            seen = 1'b1;
            n_act++;
            if (in_ready) n_rdy++;
         end else if (seen) begin
            done = 1'b1;
         end
         if (!done) begin
            acc = busy && in_ready && pix_in_valid;
            @(posedge clk);
            #1;
            if (acc) begin
               idx++;
               pix_in_valid = bubble ? 1'b0 : (idx < R * C);
            end else if (!pix_in_valid) begin
               pix_in_valid = (idx < R * C);
            end
            pix_in = (idx < R * C) ? 8'(idx + 1) : 8'd0;
            if (flip && idx == 10) border_mode = ~mode;
            if (abort_at != 0 && idx == abort_at) begin
               reset_in = 1'b1;
               pix_in_valid = 1'b0;
               #1;
               check_reset_outputs("async reset mid-frame");
               done = 1'b1;
            end
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout: frame did not finish within 400 cycles, required finish");
      end
      pix_in_valid = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      int na, nr;
      run_frame(v.mode, v.bubble, v.flip, 0, na, nr);
      repeat (3) @(negedge clk);
      total++;
      if (n_win != v.exp_win) begin
         bad++;
         $display("FAIL %s count: got %0d windows, required %0d", name, n_win, v.exp_win);
      end else $display("%s count: %0d windows", name, n_win);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL %s pending: got %0d windows missing, required 0", name, sb_q.size());
      end
      if (v.exp_active >= 0) begin
         total++;
         if (na != v.exp_active) begin
            bad++;
            $display("FAIL %s active: got %0d busy cycles, required %0d", name, na, v.exp_active);
         end else $display("%s active: %0d busy cycles", name, na);
      end
      if (v.exp_ready >= 0) begin
         total++;
         if (nr != v.exp_ready) begin
            bad++;
            $display("FAIL %s ready: got %0d ready cycles, required %0d", name, nr, v.exp_ready);
         end else $display("%s ready: %0d ready cycles", name, nr);
      end
      total++;
      if (first_w !== v.first || last_w !== v.last) begin
         bad++;
         $display("FAIL %s first/last: got %h / %h, required %h / %h",
                  name, first_w, last_w, v.first, v.last);
      end else $display("%s first=%h last=%h", name, first_w, last_w);
      sb_q.delete();
   endtask

   initial begin
      logic [WW-1:0] f0, l0, f1, l1;
      int na, nr;
      f0 = mk9('{1, 2, 3, 6, 7, 8, 11, 12, 13});
      l0 = mk9('{13, 14, 15, 18, 19, 20, 23, 24, 25});
      f1 = mk9('{0, 0, 0, 0, 1, 2, 0, 6, 7});
      l1 = mk9('{19, 20, 0, 24, 25, 0, 0, 0, 0});
      //          mode bub flip win act ready first last
      vecs[0] = '{1'b0, 1'b0, 1'b0, 9,  25, 25, f0, l0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 25, 49, 25, f1, l1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 25, -1, -1, f1, l1};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 25, 49, 25, f1, l1};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 9,  25, 25, f0, l0};

      sb_en        = 1'b1;
      reset_in     = 1'b1;
      pix_in_valid = 1'b0;
      pix_in       = '0;
      border_mode  = 1'b0;
      #1;
      check_reset_outputs("power-on reset");
      repeat (3) @(negedge clk);
      reset_in = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Abort a zero-pad frame after 12 pixels, then a clean frame must match
      sb_en = 1'b0;
      run_frame(1'b1, 1'b0, 1'b0, 12, na, nr);
      repeat (2) @(negedge clk);
      reset_in = 1'b0;
      sb_q.delete();
      @(negedge clk);
      sb_en = 1'b1;
      apply_vec(vecs[1], "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
